// File: rtl/bpsk_pkg.sv
// Shared types and elaboration-time helpers for the BPSK modulator.
// The sine helper only runs while parameters are resolved, so its real arithmetic never reaches hardware.
package bpsk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int calc_sps(input int depth, input int cyc_per_sym);
        return depth * cyc_per_sym;
    endfunction

    function automatic int calc_idx_w(input int depth, input int cyc_per_sym);
        return $clog2(depth * cyc_per_sym);
    endfunction

    // Rounds half away from zero, so the table is symmetric and the amplitude stays 2^(w-1)-1.
    function automatic int sine_val(input int k, input int depth, input int width);
        real amp;
        real x;
        int  v;
        amp = real'((1 << (width - 1)) - 1);
        x   = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(depth));
        if (x >= 0.0) v = $rtoi(x + 0.5);
        else          v = -$rtoi(-x + 0.5);
        return v;
    endfunction

endpackage

// File: rtl/bpsk_mod_stream_if.sv
// Symbol input and sample output bundle of the BPSK modulator.
// A symbol transfers on the rising clk edge where sym_valid && sym_ready; sym_valid may drop at any time.
interface bpsk_mod_stream_if #(
    parameter int DATA_W = 8
);
    logic                     sym_valid;
    logic                     sym_ready;
    logic                     sym_bit;
    logic                     diff_en;
    logic signed [DATA_W-1:0] sample;
    logic                     sample_valid;
    logic                     sym_start;
    logic                     underrun;

    modport master (
        output sym_valid, sym_bit, diff_en,
        input  sym_ready, sample, sample_valid, sym_start, underrun
    );

    modport slave (
        input  sym_valid, sym_bit, diff_en,
        output sym_ready, sample, sample_valid, sym_start, underrun
    );
endinterface

// File: rtl/bpsk_sine_rom.sv
// One carrier cycle of signed sine samples, fixed when parameters are resolved.
module bpsk_sine_rom
    import bpsk_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LUT_DEPTH = 32
) (
    input  logic [$clog2(LUT_DEPTH)-1:0] addr_i,
    output logic signed [DATA_W-1:0]     value_o
);
    logic signed [DATA_W-1:0] rom [LUT_DEPTH];

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
        localparam int V = sine_val(k, LUT_DEPTH, DATA_W);
        assign rom[k] = DATA_W'(V);
    end

    assign value_o = rom[addr_i];
endmodule

// File: rtl/bpsk_mod_stream.sv
// BPSK modulator: one-entry symbol buffer, IDLE/RUN sample engine, optional differential encoding.
// Outputs are registered from next-state values so the first sample appears one edge after a load.
module bpsk_mod_stream
    import bpsk_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int LUT_DEPTH   = 32,
    parameter int CYC_PER_SYM = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    bpsk_mod_stream_if.slave   bus,
    output state_e             dbg_state_o
);
    localparam int SPS    = calc_sps(LUT_DEPTH, CYC_PER_SYM);
    localparam int IDX_W  = calc_idx_w(LUT_DEPTH, CYC_PER_SYM);
    localparam int ADDR_W = $clog2(LUT_DEPTH);

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     hold_full_q, hold_full_d;
    logic                     hold_bit_q, hold_bit_d;
    logic                     ref_q, ref_d;
    logic signed [DATA_W-1:0] sample_q, sample_d;
    logic                     sample_valid_q;
    logic                     sym_start_q;
    logic                     underrun_q;

    logic                     accept;
    logic                     at_end;
    logic                     load;
    logic                     load_phase;
    logic [ADDR_W-1:0]        rom_addr;
    logic signed [DATA_W-1:0] rom_val;

    bpsk_sine_rom #(
        .DATA_W    (DATA_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_rom (
        .addr_i  (rom_addr),
        .value_o (rom_val)
    );

    // ref_q always holds the phase of the symbol on air, in both modes.
    always_comb begin
        accept      = bus.sym_valid && !hold_full_q;
        at_end      = (state_q == RUN) && (idx_q == IDX_W'(SPS - 1));
        load        = hold_full_q && ((state_q == IDLE) || at_end);
        load_phase  = (bus.diff_en & ref_q) ^ hold_bit_q;

        hold_full_d = hold_full_q;
        hold_bit_d  = hold_bit_q;
        if (load) hold_full_d = 1'b0;
        if (accept) begin
            hold_full_d = 1'b1;
            hold_bit_d  = bus.sym_bit;
        end

        state_d = state_q;
        idx_d   = idx_q;
        ref_d   = ref_q;
        if (load) begin
            state_d = RUN;
            idx_d   = '0;
            ref_d   = load_phase;
        end else if (at_end) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (state_q == RUN) begin
            idx_d = idx_q + IDX_W'(1);
        end

        rom_addr = idx_d[ADDR_W-1:0];
        sample_d = '0;
        if (state_d == RUN) sample_d = ref_d ? -rom_val : rom_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            hold_full_q    <= 1'b0;
            hold_bit_q     <= 1'b0;
            ref_q          <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            sym_start_q    <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            hold_full_q    <= hold_full_d;
            hold_bit_q     <= hold_bit_d;
            ref_q          <= ref_d;
            sample_q       <= sample_d;
            sample_valid_q <= (state_d == RUN);
            sym_start_q    <= load;
            underrun_q     <= at_end && !hold_full_q;
        end
    end

    assign bus.sym_ready    = !hold_full_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.sym_start    = sym_start_q;
    assign bus.underrun     = underrun_q;
    assign dbg_state_o      = state_q;
endmodule
